// File: rtl/riscv_div_tag_unit_pkg.sv
// Shared EX-stage definitions for the divider/tag unit.
// Holds the ALU divide operator codes, the DIFT tag-propagation mode codes,
// the INTEGER policy field position in the TPR, and the divider FSM states.
package riscv_div_tag_unit_pkg;

  // Divide/remainder group: bit0 = signed, bit1 = remainder
  localparam logic [5:0] ALU_DIVU = 6'b110000;
  localparam logic [5:0] ALU_DIV  = 6'b110001;
  localparam logic [5:0] ALU_REMU = 6'b110010;
  localparam logic [5:0] ALU_REM  = 6'b110011;

  // Tag propagation modes
  localparam logic [1:0] ALU_MODE_OLD   = 2'b00;
  localparam logic [1:0] ALU_MODE_AND   = 2'b01;
  localparam logic [1:0] ALU_MODE_OR    = 2'b10;
  localparam logic [1:0] ALU_MODE_CLEAR = 2'b11;

  // INTEGER-class policy field inside the tag propagation register
  localparam int INTEGER_LOW  = 0;
  localparam int INTEGER_HIGH = 1;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_FIX,
    DIV_DONE
  } div_state_e;

  // The four div/rem codes share the upper four operator bits
  function automatic logic is_div_op(input logic [5:0] op);
    return op[5:2] == ALU_DIVU[5:2];
  endfunction

endpackage

// File: rtl/riscv_tag_policy_mux.sv
// Combinational DIFT tag policy selector, shared by EX-stage units.
// Ports:
//   mode_i   - ALU_MODE_* policy code
//   tag_a_i  - tag of rs1
//   tag_b_i  - tag of rs2
//   tag_rd_i - current tag of rd
//   tag_o    - propagated result tag
module riscv_tag_policy_mux
  import riscv_div_tag_unit_pkg::*;
(
  input  logic [1:0] mode_i,
  input  logic       tag_a_i,
  input  logic       tag_b_i,
  input  logic       tag_rd_i,
  output logic       tag_o
);

  always_comb begin
    tag_o = 1'b0;
    case (mode_i)
      ALU_MODE_OLD:   tag_o = tag_rd_i;
      ALU_MODE_AND:   tag_o = tag_a_i & tag_b_i;
      ALU_MODE_OR:    tag_o = tag_a_i | tag_b_i;
      ALU_MODE_CLEAR: tag_o = 1'b0;
      default:        tag_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/riscv_div_tag_unit.sv
// Iterative radix-2 restoring divider/remainder unit with DIFT tag output.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   enable_i            - start request, sampled only while idle
//   operator_i          - ALU_DIVU/ALU_DIV/ALU_REMU/ALU_REM
//   op_a_i, op_b_i      - dividend, divisor
//   tag_a_i, tag_b_i    - operand tags; tag_rd_i - current rd tag
//   tpr_i               - tag propagation policy register
//   flush_i             - abort the operation in flight
//   ex_ready_i          - downstream accepts the result
//   ready_o             - idle and able to accept
//   valid_o, result_o, tag_o - result handshake, data and tag
module riscv_div_tag_unit
  import riscv_div_tag_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TPR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic [5:0]            operator_i,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  input  logic                  tag_a_i,
  input  logic                  tag_b_i,
  input  logic                  tag_rd_i,
  input  logic [TPR_WIDTH-1:0]  tpr_i,
  input  logic                  flush_i,
  input  logic                  ex_ready_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  tag_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;     // dividend shifting out, quotient shifting in
  logic [DATA_WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  op_rem_q, op_rem_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  tag_q, tag_d;

  logic                  policy_tag;
  logic                  op_signed, a_neg, b_neg, div_zero, sgn_ovf;
  logic [DATA_WIDTH-1:0] a_abs, b_abs;
  logic [DATA_WIDTH:0]   trial;
  logic                  unused_tpr;

  riscv_tag_policy_mux u_tag_policy (
    .mode_i   (tpr_i[INTEGER_HIGH:INTEGER_LOW]),
    .tag_a_i  (tag_a_i),
    .tag_b_i  (tag_b_i),
    .tag_rd_i (tag_rd_i),
    .tag_o    (policy_tag)
  );

  // Other policy classes in the TPR are not relevant to integer division
  assign unused_tpr = ^tpr_i;

  assign op_signed = operator_i[0];
  assign a_neg     = op_signed & op_a_i[DATA_WIDTH-1];
  assign b_neg     = op_signed & op_b_i[DATA_WIDTH-1];
  assign a_abs     = a_neg ? -op_a_i : op_a_i;
  assign b_abs     = b_neg ? -op_b_i : op_b_i;
  assign div_zero  = (op_b_i == '0);
  assign sgn_ovf   = op_signed & (op_a_i == MIN_NEG) & (&op_b_i);

  // Restoring step: bring down the next dividend bit and try to subtract
  assign trial = {rem_q, quo_q[DATA_WIDTH-1]} - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    op_rem_d  = op_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    tag_d     = tag_q;

    if (flush_i) begin
      state_d = DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (enable_i && is_div_op(operator_i)) begin
            op_rem_d  = operator_i[1];
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            tag_d     = policy_tag;
            quo_d     = a_abs;
            dvs_d     = b_abs;
            rem_d     = '0;
            cnt_d     = '1;
            if (div_zero) begin
              result_d = operator_i[1] ? op_a_i : '1;
              state_d  = DIV_DONE;
            end else if (sgn_ovf) begin
              result_d = operator_i[1] ? '0 : MIN_NEG;
              state_d  = DIV_DONE;
            end else begin
              state_d  = DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          rem_d = trial[DATA_WIDTH] ? {rem_q[DATA_WIDTH-2:0], quo_q[DATA_WIDTH-1]}
                                    : trial[DATA_WIDTH-1:0];
          quo_d = {quo_q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_d = DIV_FIX;
        end
        DIV_FIX: begin
          // Quotient negative when signs differ; remainder follows dividend
          if (op_rem_q) result_d = neg_rem_q ? -rem_q : rem_q;
          else          result_d = neg_quo_q ? -quo_q : quo_q;
          state_d = DIV_DONE;
        end
        DIV_DONE: begin
          if (ex_ready_i) state_d = DIV_IDLE;
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      op_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      tag_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      op_rem_q  <= op_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      tag_q     <= tag_d;
    end
  end

  assign ready_o  = (state_q == DIV_IDLE);
  assign valid_o  = (state_q == DIV_DONE);
  assign result_o = result_q;
  assign tag_o    = tag_q;

endmodule

// File: tb/tb_riscv_div_tag_unit.sv
module tb_riscv_div_tag_unit;

  localparam logic [5:0] OP_DIVU = 6'b110000;
  localparam logic [5:0] OP_DIV  = 6'b110001;
  localparam logic [5:0] OP_REMU = 6'b110010;
  localparam logic [5:0] OP_REM  = 6'b110011;
  localparam logic [1:0] M_OLD = 2'd0, M_AND = 2'd1, M_OR = 2'd2, M_CLR = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic [5:0]  operator_i;
  logic [31:0] op_a_i, op_b_i;
  logic        tag_a_i, tag_b_i, tag_rd_i;
  logic [15:0] tpr_i;
  logic        flush_i, ex_ready_i;
  logic        ready_o, valid_o, tag_o;
  logic [31:0] result_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  riscv_div_tag_unit #(.DATA_WIDTH(32), .TPR_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (enable_i),
    .operator_i (operator_i),
    .op_a_i     (op_a_i),
    .op_b_i     (op_b_i),
    .tag_a_i    (tag_a_i),
    .tag_b_i    (tag_b_i),
    .tag_rd_i   (tag_rd_i),
    .tpr_i      (tpr_i),
    .flush_i    (flush_i),
    .ex_ready_i (ex_ready_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .result_o   (result_o),
    .tag_o      (tag_o)
  );

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ta;
    logic        tb;
    logic        trd;
    logic [1:0]  mode;
    logic [31:0] exp_res;
    logic        exp_tag;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: architectural RISC-V M-extension division rules
  function automatic logic [31:0] model_res(input logic [5:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] q, r;
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic logic model_tag(input logic [1:0] mode, input logic ta, input logic tb,
                                     input logic trd);
    case (mode)
      M_OLD:   return trd;
      M_AND:   return ta & tb;
      M_OR:    return ta | tb;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int model_lat(input logic [5:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Present an operation in IDLE; returns just after the accepting edge with
  // the inputs scrambled so that only latched values can matter.
  task automatic start_op(input vec_t v);
    int n = 0;
    @(negedge clk);
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      errors++;
      checks++;
      $display("FAIL ready_timeout: got ready_o=0 expected 1 within 100 cycles");
    end
    enable_i   = 1'b1;
    operator_i = v.op;
    op_a_i     = v.a;
    op_b_i     = v.b;
    tag_a_i    = v.ta;
    tag_b_i    = v.tb;
    tag_rd_i   = v.trd;
    tpr_i      = {14'($urandom), v.mode};
    @(posedge clk);
    #1;
    enable_i   = 1'b0;
    op_a_i     = $urandom;
    op_b_i     = $urandom;
    tag_a_i    = ~v.ta;
    tag_b_i    = ~v.tb;
    tag_rd_i   = ~v.trd;
    tpr_i      = 16'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!valid_o) begin
      errors++;
      checks++;
      $display("FAIL valid_timeout: got valid_o=0 expected 1 within 100 cycles");
      lat = 999;
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int lat;
    start_op(v);
    wait_valid(lat);
    chk({name, "_lat"}, 32'(lat), 32'(v.exp_lat));
    chk({name, "_res"}, result_o, v.exp_res);
    chk({name, "_tag"}, {31'd0, tag_o}, {31'd0, v.exp_tag});
  endtask

  initial begin
    vec_t v;
    int   lat;
    int   seen;
    int   sel;

    rst_n = 1'b0; enable_i = 1'b0; operator_i = '0; op_a_i = '0; op_b_i = '0;
    tag_a_i = 1'b0; tag_b_i = 1'b0; tag_rd_i = 1'b0; tpr_i = '0;
    flush_i = 1'b0; ex_ready_i = 1'b1;

    vecs.push_back('{OP_DIVU, 32'd100,        32'd7,          1, 0, 0, M_OR,  32'd14,         1, 34});
    vecs.push_back('{OP_REMU, 32'd100,        32'd7,          1, 0, 0, M_OR,  32'd2,          1, 34});
    vecs.push_back('{OP_DIV,  32'hFFFF_FF9C,  32'd7,          1, 0, 0, M_AND, 32'hFFFF_FFF2,  0, 34});
    vecs.push_back('{OP_REM,  32'hFFFF_FF9C,  32'd7,          1, 0, 0, M_AND, 32'hFFFF_FFFE,  0, 34});
    vecs.push_back('{OP_DIV,  32'd100,        32'hFFFF_FFF9,  1, 1, 0, M_AND, 32'hFFFF_FFF2,  1, 34});
    vecs.push_back('{OP_REM,  32'd100,        32'hFFFF_FFF9,  0, 1, 0, M_OR,  32'd2,          1, 34});
    vecs.push_back('{OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  0, 0, 1, M_OLD, 32'd14,         1, 34});
    vecs.push_back('{OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  0, 0, 0, M_OLD, 32'hFFFF_FFFE,  0, 34});
    vecs.push_back('{OP_DIV,  32'd5,          32'd0,          1, 1, 0, M_CLR, 32'hFFFF_FFFF,  0, 1});
    vecs.push_back('{OP_REM,  32'd5,          32'd0,          1, 1, 1, M_CLR, 32'd5,          0, 1});
    vecs.push_back('{OP_DIVU, 32'd5,          32'd0,          0, 1, 0, M_OR,  32'hFFFF_FFFF,  1, 1});
    vecs.push_back('{OP_REM,  32'hFFFF_FFF9,  32'd0,          1, 1, 0, M_AND, 32'hFFFF_FFF9,  1, 1});
    vecs.push_back('{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  0, 0, 1, M_OLD, 32'h8000_0000,  1, 1});
    vecs.push_back('{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  1, 1, 1, M_OLD, 32'd0,          1, 1});
    vecs.push_back('{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  0, 0, 0, M_OLD, 32'd0,          0, 34});
    vecs.push_back('{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  1, 1, 0, M_AND, 32'h8000_0000,  1, 34});
    vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          0, 0, 0, M_OR,  32'hFFFF_FFFF,  0, 34});
    vecs.push_back('{OP_DIV,  32'h8000_0000,  32'd1,          1, 1, 1, M_CLR, 32'h8000_0000,  0, 34});

    // Reset state
    #1;
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_tag", {31'd0, tag_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Non-divide operator is ignored
    @(negedge clk);
    enable_i = 1'b1; operator_i = 6'b011000; op_a_i = 32'd9; op_b_i = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("nondiv_ready", {31'd0, ready_o}, 32'd1);
    chk("nondiv_valid", {31'd0, valid_o}, 32'd0);
    enable_i = 1'b0;

    // flush_i wins over enable_i in IDLE
    @(negedge clk);
    enable_i = 1'b1; operator_i = OP_DIVU; op_a_i = 32'd50; op_b_i = 32'd0; flush_i = 1'b1;
    @(posedge clk);
    #1;
    enable_i = 1'b0; flush_i = 1'b0;
    chk("flush_pri_ready", {31'd0, ready_o}, 32'd1);
    @(posedge clk);
    #1;
    chk("flush_pri_valid", {31'd0, valid_o}, 32'd0);

    // Hold in DONE with ex_ready_i low; enable_i during DONE is ignored
    ex_ready_i = 1'b0;
    start_op('{OP_DIVU, 32'd1000, 32'd10, 1, 1, 0, M_AND, 32'd100, 1, 34});
    wait_valid(lat);
    chk("hold_lat", 32'(lat), 32'd34);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      enable_i = 1'b1; operator_i = OP_DIV; op_a_i = $urandom; op_b_i = 32'd0;
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_valid", i), {31'd0, valid_o}, 32'd1);
      chk($sformatf("hold%0d_ready", i), {31'd0, ready_o}, 32'd0);
      chk($sformatf("hold%0d_res", i), result_o, 32'd100);
    end
    @(negedge clk);
    enable_i = 1'b0; ex_ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("release_ready", {31'd0, ready_o}, 32'd1);
    chk("release_valid", {31'd0, valid_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("release_idle", {31'd0, ready_o}, 32'd1);

    // Flush in the middle of DIV
    start_op('{OP_DIVU, 32'd100, 32'd7, 1, 0, 0, M_OR, 32'd14, 1, 34});
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk("flush_ready", {31'd0, ready_o}, 32'd1);
    chk("flush_valid", {31'd0, valid_o}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (valid_o) seen++;
    end
    chk("flush_no_valid", 32'(seen), 32'd0);
    run_vec(vecs[2], "after_flush");

    // Asynchronous reset in the middle of DIV (outputs non-zero beforehand)
    run_vec(vecs[0], "pre_reset");
    start_op(vecs[3]);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'd0, ready_o}, 32'd1);
    chk("arst_valid", {31'd0, valid_o}, 32'd0);
    chk("arst_result", result_o, 32'd0);
    chk("arst_tag", {31'd0, tag_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[4], "after_reset");

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      v.op   = OP_DIVU + 6'($urandom_range(0, 3));
      v.a    = $urandom;
      sel    = $urandom_range(0, 7);
      case (sel)
        0: v.b = 32'd0;
        1: begin v.a = 32'h8000_0000; v.b = 32'hFFFF_FFFF; end
        2: v.b = 32'($urandom_range(1, 20));
        3: begin v.a = 32'($urandom_range(0, 1000)); v.b = $urandom; end
        default: v.b = $urandom;
      endcase
      v.ta      = 1'($urandom);
      v.tb      = 1'($urandom);
      v.trd     = 1'($urandom);
      v.mode    = 2'($urandom);
      v.exp_res = model_res(v.op, v.a, v.b);
      v.exp_tag = model_tag(v.mode, v.ta, v.tb, v.trd);
      v.exp_lat = model_lat(v.op, v.a, v.b);
      run_vec(v, $sformatf("rnd%0d_op%h_a%h_b%h", i, v.op, v.a, v.b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
